fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, meaning the PC loaded on reset (word-aligned).
REQ-002 SHALL have parameter QDEPTH, default 2, meaning the prefetch queue depth (power of two, at least 2).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port imem_addr  output  32  byte address driven to the instruction ROM.
REQ-006 SHALL have port imem_instr  input  32  combinational ROM read data for imem_addr.
REQ-007 SHALL have port redirect_valid  input  1  branch/jump taken; PC reload request.
REQ-008 SHALL have port redirect_pc  input  32  target byte address.
REQ-009 SHALL have port out_valid  output  1  queue head valid toward decode.
REQ-010 SHALL have port out_ready  input  1  decode accepts head.
REQ-011 SHALL have port out_pc  output  32  PC of the head entry.
REQ-012 SHALL have port out_instr  output  32  instruction word of the head entry.
REQ-013 SHALL have port fetch_fault  output  1  sticky misalignment fault; present only with FETCH_MISALIGN_EN.

Function
REQ-014 SHALL drive imem_addr combinationally from the PC register; the PC register's bits [1:0] SHALL always be 00.
REQ-015 SHALL push {pc, imem_instr} and advance pc by 4 on an edge where no redirect occurs and either count<QDEPTH or a pop occurs.
REQ-016 SHALL hold pc and imem_addr stable while the queue is full and no pop occurs.
REQ-017 SHALL drive out_valid = (count!=0), with out_pc and out_instr taken from the head entry; a pop occurs on out_valid && out_ready.
REQ-018 SHALL give redirect highest priority: on that edge count:=0 and pc:=redirect_pc; a pop in the same cycle completes but the push is dropped.
REQ-019 SHALL make latency one cycle: the entry for the PC fetched at edge N is visible at the outputs after edge N, and after a redirect at edge N the target is visible after edge N+1.
REQ-020 SHALL compute pc+4 modulo 2^32 (0xFFFFFFFC -> 0x00000000).
REQ-021 SHALL support simultaneous push and pop when full, leaving count unchanged with FIFO order preserved and no loss or duplication.
REQ-022 SHALL hold out_pc and out_instr stable while out_valid && !out_ready.
REQ-023 SHALL describe occupancy in terms of the states EMPTY (count=0), PARTIAL and FULL (count=QDEPTH); these are derived from count, not a separate FSM.

Reset
REQ-024 SHALL, while rst_n=0 and regardless of clk, set pc=RESET_PC, count=0, read/write pointers=0, out_valid=0 and fetch_fault=0.
REQ-025 SHALL discard all queued entries when reset is asserted mid-operation, and SHALL make the first push occur on the first rising edge after rst_n deasserts.

Configuration
REQ-026 SHALL use macro FETCH_MISALIGN_EN: when defined, a redirect with redirect_pc[1:0]!=0 sets fetch_fault=1, flushes the queue and stops all pushes until reset (out_valid stays 0).
REQ-027 SHALL, when FETCH_MISALIGN_EN is undefined, omit the fetch_fault port and load the PC from redirect_pc with bits [1:0] forced to 00.

Structure
REQ-028 SHALL take from shared package cpu_pkg: XLEN=32, INSTR_NOP=32'h00000000, DEFAULT_RESET_PC, and typedef fetch_entry_t {pc[31:0], instr[31:0]}.
REQ-029 SHALL implement the queue as sub-module fetch_queue (QDEPTH entries of fetch_entry_t, push/pop/flush, count output); the PC logic and redirect logic stay in fetch_stage.

Verification
REQ-030 SHALL cover: ROM holds 0x20020005, 0x20030003 and 0x00430820 at addresses 0, 4 and 8; reset released with out_ready=1 -> outputs (pc 0, 20020005), (pc 4, 20030003), (pc 8, 00430820) on consecutive cycles starting the cycle after the first edge.
REQ-031 SHALL cover: out_ready=0 for 5 cycles -> count=2, imem_addr holds at 0x8; out_ready=1 -> pc 0, 4, 8 delivered in order with no gaps or duplicates.
REQ-032 SHALL cover: redirect_valid=1 with redirect_pc=0x40 while FULL -> out_valid=0 the next cycle, then out_pc=0x40 followed by 0x44.
REQ-033 SHALL cover: redirect to 0xFFFFFFFC -> out_pc sequence 0xFFFFFFFC, 0x00000000, 0x00000004.
REQ-034 SHALL cover: rst_n driven low between clock edges with count=2 -> out_valid=0 and imem_addr=RESET_PC immediately, without waiting for an edge.
REQ-035 SHALL cover: redirect_pc=0x42 -> with FETCH_MISALIGN_EN, fetch_fault=1 and out_valid stays 0 until reset; without it, the next out_pc=0x40.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: data width, NOP encoding, reset PC default,
// the fetch queue entry type and the queue occupancy classification.
package cpu_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h00000000;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h00000000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Occupancy view of the prefetch queue, derived from its count
  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_t;

  function automatic occ_t occ_from(input logic is_empty, input logic is_full);
    if (is_empty) begin
      return OCC_EMPTY;
    end
    if (is_full) begin
      return OCC_FULL;
    end
    return OCC_PARTIAL;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of fetch_entry_t with push, pop and flush.
// The caller never pushes into a full queue unless it pops on the same edge,
// and never pops an empty queue. Flush wins over push and pop.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  // Storage write; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; flush empties the queue in one edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + AW'(1);
      end
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rptr];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, redirect handling and a prefetch
// queue toward decode. Optional feature macro: FETCH_MISALIGN_EN, which turns
// a misaligned redirect into a sticky fault that halts fetch until reset.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          QDEPTH   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_instr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr
`ifdef FETCH_MISALIGN_EN
  ,
  output logic            fetch_fault
`endif
);

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(QDEPTH);
  localparam logic [XLEN-1:0] RESET_PC_ALIGNED = {RESET_PC[XLEN-1:2], 2'b00};

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] target;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;
  logic            halted;
  occ_t            occ;
  fetch_entry_t    head;
  fetch_entry_t    push_entry;

  assign target = {redirect_pc[XLEN-1:2], 2'b00};

`ifdef FETCH_MISALIGN_EN
  logic fault;

  // Sticky fault on any redirect to a non-word-aligned target
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault <= 1'b0;
    end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
      fault <= 1'b1;
    end
  end

  assign halted      = fault;
  assign fetch_fault = fault;
`else
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign halted = 1'b0;
`endif

  // Handshake decisions: redirect drops the push, a full queue needs a pop
  always_comb begin
    occ  = occ_from(count == '0, count == FULL_CNT);
    pop  = (occ != OCC_EMPTY) && out_ready;
    push = !redirect_valid && !halted && ((occ != OCC_FULL) || pop);
  end

  // PC register: redirect first, otherwise advance only when a push happens
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC_ALIGNED;
    end else if (redirect_valid) begin
      pc <= target;
    end else if (push) begin
      pc <= pc + 32'd4;
    end
  end

  assign imem_addr        = pc;
  assign push_entry.pc    = pc;
  assign push_entry.instr = imem_instr;

  fetch_queue #(
    .DEPTH(QDEPTH)
  ) u_queue (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redirect_valid),
    .push     (push),
    .push_data(push_entry),
    .pop      (pop),
    .head     (head),
    .count    (count)
  );

  assign out_valid = (occ != OCC_EMPTY);
  assign out_pc    = out_valid ? head.pc    : '0;
  assign out_instr = out_valid ? head.instr : INSTR_NOP;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage with a small combinational ROM model.
// Honours FETCH_MISALIGN_EN in the same way as the design.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
`ifdef FETCH_MISALIGN_EN
  logic        fetch_fault;
`endif

  int checks;
  int failures;

  fetch_stage #(
    .RESET_PC(32'h00000000),
    .QDEPTH  (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_instr     (out_instr)
`ifdef FETCH_MISALIGN_EN
    ,
    .fetch_fault   (fetch_fault)
`endif
  );

  // ROM contents: three real words, everything else a recognisable pattern
  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    case (addr)
      32'h0:   return 32'h20020005;
      32'h4:   return 32'h20030003;
      32'h8:   return 32'h00430820;
      default: return addr ^ 32'hDEAD0000;
    endcase
  endfunction

  assign imem_instr = rom_word(imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s got=%h want=%h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic rdy, input logic rv, input logic [31:0] rpc);
    rst_n          = rst;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks         = 0;
    failures       = 0;
    rst_n          = 1'b0;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    // Reset state and straight-line delivery of the three ROM words
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_addr", imem_addr, 32'h0);
`ifdef FETCH_MISALIGN_EN
    checkOutput("rst_fault", 32'(fetch_fault), 32'd0);
`endif
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("seq0_valid", 32'(out_valid), 32'd1);
    checkOutput("seq0_pc", out_pc, 32'h0);
    checkOutput("seq0_instr", out_instr, 32'h20020005);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("seq1_pc", out_pc, 32'h4);
    checkOutput("seq1_instr", out_instr, 32'h20030003);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("seq2_pc", out_pc, 32'h8);
    checkOutput("seq2_instr", out_instr, 32'h00430820);

    // Back-pressure: queue fills to two and the PC stalls at 0x8
    rst_n     = 1'b0;
    out_ready = 1'b0;
    #3;
    checkOutput("rst2_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput("stall_pc", out_pc, 32'h0);
    end
    checkOutput("stall_valid", 32'(out_valid), 32'd1);
    checkOutput("stall_addr", imem_addr, 32'h8);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("drain1_pc", out_pc, 32'h4);
    checkOutput("drain1_instr", out_instr, 32'h20030003);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("drain2_pc", out_pc, 32'h8);
    checkOutput("drain2_instr", out_instr, 32'h00430820);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("drain3_pc", out_pc, 32'hC);
    checkOutput("drain3_instr", out_instr, rom_word(32'hC));

    // Redirect while full: flush, then target and target+4
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h40);
    checkOutput("redir_valid", 32'(out_valid), 32'd0);
    checkOutput("redir_addr", imem_addr, 32'h40);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("redir_pc0", out_pc, 32'h40);
    checkOutput("redir_instr0", out_instr, rom_word(32'h40));
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("redir_pc1", out_pc, 32'h44);

    // PC wrap-around past the top of the address space
    applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFFFFFC);
    checkOutput("wrap_flush", 32'(out_valid), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("wrap_pc0", out_pc, 32'hFFFFFFFC);
    checkOutput("wrap_instr0", out_instr, rom_word(32'hFFFFFFFC));
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("wrap_pc1", out_pc, 32'h0);
    checkOutput("wrap_instr1", out_instr, 32'h20020005);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("wrap_pc2", out_pc, 32'h4);

    // Asynchronous reset between edges with two entries queued
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("pre_rst_valid", 32'(out_valid), 32'd1);
    checkOutput("pre_rst_addr", imem_addr, 32'hC);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_valid", 32'(out_valid), 32'd0);
    checkOutput("async_addr", imem_addr, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("post_rst_valid", 32'(out_valid), 32'd1);
    checkOutput("post_rst_pc", out_pc, 32'h0);

    // Misaligned redirect target
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h42);
    checkOutput("mis_flush", 32'(out_valid), 32'd0);
`ifdef FETCH_MISALIGN_EN
    checkOutput("mis_fault", 32'(fetch_fault), 32'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("mis_halt_valid", 32'(out_valid), 32'd0);
      checkOutput("mis_halt_fault", 32'(fetch_fault), 32'd1);
    end
`else
    checkOutput("mis_addr", imem_addr, 32'h40);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("mis_pc0", out_pc, 32'h40);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("mis_pc1", out_pc, 32'h44);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
